// File: rtl/evm_core.sv
// evm_core: three-candidate electronic voting machine controller with registered readout
// Ports:
//   clk                  rising-edge clock
//   rst                  asynchronous active-low reset (clears state and all counters)
//   switch_on_evm        machine enable; low drops to OFF except once results are shown
//   candidate_ready      officer arms one ballot
//   vote_candidate_1/2/3 voter buttons
//   voting_session_done  closes the session (terminal until reset)
//   display_results      candidate select for readout (0..2, 3 = invalid)
//   display_winner       winner readout request, overrides display_results
//   candidate_name       readout candidate index 1..3, 0 = none
//   invalid_results      bad ballot pulse, or invalid readout flag
//   results              readout count
//   voting_in_progress   high in READY, BALLOT, LOCK
//   voting_done          high in RESULTS
// Build option: define EVM_VOTE_TIMEOUT_EN to abandon an armed ballot after
// TIMEOUT_CYCLES cycles without a valid vote.
module evm_core #(
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             switch_on_evm,
  input  logic             candidate_ready,
  input  logic             vote_candidate_1,
  input  logic             vote_candidate_2,
  input  logic             vote_candidate_3,
  input  logic             voting_session_done,
  input  logic [1:0]       display_results,
  input  logic             display_winner,
  output logic [1:0]       candidate_name,
  output logic             invalid_results,
  output logic [WIDTH-1:0] results,
  output logic             voting_in_progress,
  output logic             voting_done
);
  typedef enum logic [2:0] {OFF, READY, BALLOT, LOCK, RESULTS} state_t;
  state_t                state_q, state_d;
  logic [2:0][WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]            votes, is_max;
  logic                  one_vote, multi_vote, timeout, count_en, bad_ballot, win_bad;
  logic [WIDTH-1:0]      max01, max_cnt, sel_cnt, res_d, res_q;
  logic [1:0]            win_idx, name_d, name_q;
  logic                  inv_d, inv_q, vip_d, vip_q, vd_d, vd_q;
  assign votes      = {vote_candidate_3, vote_candidate_2, vote_candidate_1};
  assign one_vote   = $onehot(votes);
  assign multi_vote = |votes && !one_vote;
`ifdef EVM_VOTE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmr_q, tmr_d;
  // Counter is zero on every entry to BALLOT since BALLOT is only reached from READY.
  assign tmr_d   = state_q == BALLOT ? tmr_q + TW'(1) : '0;
  assign timeout = tmr_q == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tmr_q <= '0;
    else      tmr_q <= tmr_d;
  end
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= OFF;
      cnt_q   <= '0;
      res_q   <= '0;
      name_q  <= '0;
      inv_q   <= 1'b0;
      vip_q   <= 1'b0;
      vd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      name_q  <= name_d;
      inv_q   <= inv_d;
      vip_q   <= vip_d;
      vd_q    <= vd_d;
    end
  end
  // Power-off has priority everywhere but RESULTS; session close beats any vote.
  always_comb begin
    state_d = state_q;
    case (state_q)
      OFF:     state_d = switch_on_evm ? READY : OFF;
      READY:   state_d = !switch_on_evm ? OFF : voting_session_done ? RESULTS :
                         candidate_ready ? BALLOT : READY;
      BALLOT:  state_d = !switch_on_evm ? OFF : voting_session_done ? RESULTS :
                         one_vote ? LOCK : timeout ? READY : BALLOT;
      LOCK:    state_d = !switch_on_evm ? OFF : (|votes || candidate_ready) ? LOCK : READY;
      RESULTS: state_d = RESULTS;
      default: state_d = OFF;
    endcase
  end
  assign count_en   = state_q == BALLOT && state_d == LOCK;
  assign bad_ballot = state_q == BALLOT && (state_d == READY || (state_d == BALLOT && multi_vote));
  always_comb begin
    for (int i = 0; i < 3; i++)
      cnt_d[i] = (count_en && votes[i] && !(&cnt_q[i])) ? cnt_q[i] + WIDTH'(1) : cnt_q[i];
  end
  assign max01   = cnt_q[0] >= cnt_q[1] ? cnt_q[0] : cnt_q[1];
  assign max_cnt = max01 >= cnt_q[2] ? max01 : cnt_q[2];
  assign is_max  = {cnt_q[2] == max_cnt, cnt_q[1] == max_cnt, cnt_q[0] == max_cnt};
  assign win_bad = !$onehot(is_max) || max_cnt == '0;
  assign win_idx = is_max[0] ? 2'd1 : is_max[1] ? 2'd2 : 2'd3;
  assign sel_cnt = display_results[1] ? (display_results[0] ? '0 : cnt_q[2]) :
                   (display_results[0] ? cnt_q[1] : cnt_q[0]);
  // Outputs are computed from the next state so they line up with the registered state.
  always_comb begin
    vip_d  = state_d == READY || state_d == BALLOT || state_d == LOCK;
    vd_d   = state_d == RESULTS;
    res_d  = !vd_d ? '0 : display_winner ? max_cnt : sel_cnt;
    name_d = !vd_d ? 2'd0 : display_winner ? (win_bad ? 2'd0 : win_idx) :
             display_results == 2'd3 ? 2'd0 : display_results + 2'd1;
    inv_d  = !vd_d ? bad_ballot : display_winner ? win_bad : display_results == 2'd3;
  end
  assign candidate_name     = name_q;
  assign invalid_results    = inv_q;
  assign results            = res_q;
  assign voting_in_progress = vip_q;
  assign voting_done        = vd_q;
endmodule

// File: tb/tb_evm_core.sv
// tb_evm_core: directed bench for evm_core with a behavioural reference model
module tb_evm_core;
  localparam int TO = 10;
  logic       clk = 1'b0, rst = 1'b0;
  logic       switch_on_evm = 1'b0, candidate_ready = 1'b0, voting_session_done = 1'b0;
  logic       vote_candidate_1 = 1'b0, vote_candidate_2 = 1'b0, vote_candidate_3 = 1'b0;
  logic [1:0] display_results = 2'd0;
  logic       display_winner = 1'b0;
  logic [1:0] name8, name2, res2;
  logic [7:0] res8;
  logic       inv8, inv2, vip8, vip2, vd8, vd2;
  int nchk = 0, nerr = 0;
  // Model: phase 0=off 1=ready 2=ballot armed 3=locked 4=results
  int ph = 0, tmr = 0, pulse = 0;
  int raw[3] = '{0, 0, 0};

  evm_core #(.WIDTH(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .switch_on_evm(switch_on_evm), .candidate_ready(candidate_ready),
    .vote_candidate_1(vote_candidate_1), .vote_candidate_2(vote_candidate_2),
    .vote_candidate_3(vote_candidate_3), .voting_session_done(voting_session_done),
    .display_results(display_results), .display_winner(display_winner),
    .candidate_name(name8), .invalid_results(inv8), .results(res8),
    .voting_in_progress(vip8), .voting_done(vd8));

  evm_core #(.WIDTH(2), .TIMEOUT_CYCLES(TO)) dut2 (
    .clk(clk), .rst(rst), .switch_on_evm(switch_on_evm), .candidate_ready(candidate_ready),
    .vote_candidate_1(vote_candidate_1), .vote_candidate_2(vote_candidate_2),
    .vote_candidate_3(vote_candidate_3), .voting_session_done(voting_session_done),
    .display_results(display_results), .display_winner(display_winner),
    .candidate_name(name2), .invalid_results(inv2), .results(res2),
    .voting_in_progress(vip2), .voting_done(vd2));

  always #5 clk = ~clk;

  task automatic cmp(string n, int a, int e);
    nchk++;
    if (a != e) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  function automatic void readout(int w, output int r, output int nm, output int iv);
    int c[3];
    int mx, ties, idx;
    int cap = (1 << w) - 1;
    for (int i = 0; i < 3; i++) c[i] = raw[i] > cap ? cap : raw[i];
    if (display_winner) begin
      mx = 0;
      for (int i = 0; i < 3; i++) if (c[i] > mx) mx = c[i];
      ties = 0;
      idx = 0;
      for (int i = 0; i < 3; i++)
        if (c[i] == mx) begin
          ties++;
          if (idx == 0) idx = i + 1;
        end
      r = mx;
      nm = (mx == 0 || ties > 1) ? 0 : idx;
      iv = (mx == 0 || ties > 1) ? 1 : 0;
    end else if (display_results == 2'd3) begin
      r = 0; nm = 0; iv = 1;
    end else begin
      r = c[display_results]; nm = int'(display_results) + 1; iv = 0;
    end
  endfunction

  function automatic void m_step();
    int nv = int'(vote_candidate_1) + int'(vote_candidate_2) + int'(vote_candidate_3);
    pulse = 0;
    if (ph == 4) return;
    if (!switch_on_evm) begin ph = 0; return; end
    case (ph)
      0: ph = 1;
      1: if (voting_session_done) ph = 4;
         else if (candidate_ready) begin ph = 2; tmr = 0; end
      2: if (voting_session_done) ph = 4;
         else if (nv == 1) begin
           raw[vote_candidate_1 ? 0 : vote_candidate_2 ? 1 : 2]++;
           ph = 3;
         end else begin
           if (nv >= 2) pulse = 1;
           tmr++;
`ifdef EVM_VOTE_TIMEOUT_EN
           if (tmr == TO) begin ph = 1; pulse = 1; end
`endif
         end
      3: if (nv == 0 && !candidate_ready) ph = 1;
      default: ph = 0;
    endcase
  endfunction

  task automatic compare();
    int r, n, iv;
    cmp("vip8", int'(vip8), int'(ph >= 1 && ph <= 3));
    cmp("vd8", int'(vd8), int'(ph == 4));
    cmp("vip2", int'(vip2), int'(ph >= 1 && ph <= 3));
    cmp("vd2", int'(vd2), int'(ph == 4));
    if (ph == 4) readout(8, r, n, iv); else begin r = 0; n = 0; iv = pulse; end
    cmp("res8", int'(res8), r);
    cmp("name8", int'(name8), n);
    cmp("inv8", int'(inv8), iv);
    if (ph == 4) readout(2, r, n, iv); else begin r = 0; n = 0; iv = pulse; end
    cmp("res2", int'(res2), r);
    cmp("name2", int'(name2), n);
    cmp("inv2", int'(inv2), iv);
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      ph = 0; tmr = 0; pulse = 0;
      raw = '{0, 0, 0};
    end else m_step();
    #1;
    compare();
  end

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_dut();
    switch_on_evm = 0; candidate_ready = 0; voting_session_done = 0;
    vote_candidate_1 = 0; vote_candidate_2 = 0; vote_candidate_3 = 0;
    display_results = 0; display_winner = 0;
    rst = 0;
    tick(2);
    rst = 1;
  endtask

  task automatic power_on();
    switch_on_evm = 1;
    tick();
  endtask

  task automatic set_vote(int c, logic v);
    if (c == 1) vote_candidate_1 = v;
    else if (c == 2) vote_candidate_2 = v;
    else vote_candidate_3 = v;
  endtask

  task automatic ballot(int c, int hold);
    candidate_ready = 1;
    tick();
    candidate_ready = 0;
    set_vote(c, 1);
    tick(hold);
    set_vote(c, 0);
    tick(2);
  endtask

  task automatic show(logic dw, logic [1:0] dr);
    display_winner = dw;
    display_results = dr;
    tick();
  endtask

  task automatic close_session(logic dw, logic [1:0] dr);
    display_winner = dw;
    display_results = dr;
    voting_session_done = 1;
    tick();
  endtask

  initial begin
    int exp_to;
    // Reset values
    tick(2);
    cmp("rst_res", int'(res8), 0);
    cmp("rst_name", int'(name8), 0);
    cmp("rst_inv", int'(inv8), 0);
    cmp("rst_vip", int'(vip8), 0);
    cmp("rst_vd", int'(vd8), 0);
    rst = 1;
    // Three held votes for candidate 2, each counted once
    power_on();
    cmp("on_vip", int'(vip8), 1);
    repeat (3) ballot(2, 5);
    close_session(0, 2'd1);
    cmp("a_res", int'(res8), 3);
    cmp("a_name", int'(name8), 2);
    cmp("a_vd", int'(vd8), 1);
    cmp("a_vip", int'(vip8), 0);
    // Double vote: one-cycle pulse, no count, ballot stays armed
    reset_dut();
    power_on();
    candidate_ready = 1;
    tick();
    candidate_ready = 0;
    vote_candidate_1 = 1; vote_candidate_3 = 1;
    tick();
    cmp("b_inv_hi", int'(inv8), 1);
    vote_candidate_1 = 0; vote_candidate_3 = 0;
    tick();
    cmp("b_inv_lo", int'(inv8), 0);
    cmp("b_vip", int'(vip8), 1);
    vote_candidate_2 = 1;
    tick();
    vote_candidate_2 = 0;
    tick(2);
    close_session(0, 2'd0);
    cmp("b_c1", int'(res8), 0);
    show(0, 2'd2);
    cmp("b_c3", int'(res8), 0);
    show(0, 2'd1);
    cmp("b_c2_armed", int'(res8), 1);
    // Tie for winner
    reset_dut();
    power_on();
    ballot(1, 1); ballot(1, 1); ballot(2, 1); ballot(2, 1); ballot(3, 1);
    close_session(1, 2'd0);
    cmp("c_inv", int'(inv8), 1);
    cmp("c_name", int'(name8), 0);
    cmp("c_res", int'(res8), 2);
    show(0, 2'd3);
    cmp("c_sel3_inv", int'(inv8), 1);
    cmp("c_sel3_res", int'(res8), 0);
    show(0, 2'd0);
    cmp("c_sel0_res", int'(res8), 2);
    cmp("c_sel0_name", int'(name8), 1);
    // Clear winner, counts retained across power-off
    reset_dut();
    power_on();
    ballot(1, 1); ballot(1, 1); ballot(1, 1); ballot(2, 1); ballot(2, 1); ballot(3, 1);
    switch_on_evm = 0;
    tick(3);
    cmp("d_off_vip", int'(vip8), 0);
    switch_on_evm = 1;
    tick();
    close_session(1, 2'd0);
    cmp("d_name", int'(name8), 1);
    cmp("d_res", int'(res8), 3);
    cmp("d_inv", int'(inv8), 0);
    cmp("d_res2", int'(res2), 3);
    // Ballot timeout
`ifdef EVM_VOTE_TIMEOUT_EN
    exp_to = 1;
`else
    exp_to = 0;
`endif
    reset_dut();
    power_on();
    candidate_ready = 1;
    tick();
    candidate_ready = 0;
    tick(TO - 1);
    cmp("e_inv_pre", int'(inv8), 0);
    tick();
    cmp("e_inv_to", int'(inv8), exp_to);
    tick();
    cmp("e_inv_post", int'(inv8), 0);
    vote_candidate_1 = 1;
    tick();
    vote_candidate_1 = 0;
    tick(2);
    close_session(0, 2'd0);
    cmp("e_res", int'(res8), 1 - exp_to);
    // Saturation at WIDTH=2
    reset_dut();
    power_on();
    repeat (5) ballot(3, 1);
    close_session(0, 2'd2);
    cmp("f_res2_sat", int'(res2), 3);
    cmp("f_name2", int'(name2), 3);
    cmp("f_res8", int'(res8), 5);
    // Asynchronous reset mid-ballot
    reset_dut();
    power_on();
    ballot(1, 1);
    candidate_ready = 1;
    tick();
    candidate_ready = 0;
    rst = 0;
    #1;
    cmp("g_vip", int'(vip8), 0);
    cmp("g_vd", int'(vd8), 0);
    cmp("g_inv", int'(inv8), 0);
    cmp("g_res", int'(res8), 0);
    cmp("g_name", int'(name8), 0);
    tick();
    rst = 1;
    tick();
    close_session(0, 2'd0);
    cmp("g_cnt_cleared", int'(res8), 0);
    cmp("g_vd_after", int'(vd8), 1);
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
